inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  drops all in-flight entries.
REQ-005 in_valid  in  1 / in_ready  out  1  request handshake.
REQ-006 in_fmt  in  3  format code from the package: I_LOAD, I_ALU, S, B, U_LUI.
REQ-007 in_funct3  in  3 / in_funct7  in  7 (funct7 is carried but not encoded; no R format) / in_rd, in_rs1, in_rs2  in  5 each.
REQ-008 in_imm  in  32  immediate in the same form the immediate generator produces: sign-extended for I/S/B (byte offset for B), right-aligned 20-bit value for LUI.
REQ-009 out_valid  out  1 / out_ready  in  1  result handshake.
REQ-010 out_inst  out  32  encoded instruction word.
REQ-011 out_err  out  1  encoding rejected.
REQ-012 out_addr  out  32  instruction-memory byte address of out_inst.
REQ-013 ok_cnt  out  16  count of error-free results delivered; saturating.
REQ-014 err_cnt  out  8  count of rejected results delivered; saturating.

Function
REQ-015 SHALL be an elastic 2-stage pipeline: S1 packs and range-checks, S2 holds the output register.
- A transfer occurs when valid=1 and ready=1 in the same cycle.
REQ-016 Latency SHALL be 2 cycles from input transfer to out_valid; throughput 1 per cycle.
REQ-017 Each stage SHALL load when empty or when its content leaves that cycle.
- in_ready = !s1_valid | s1_moves, where s1_moves = s1_valid & (!s2_valid | out_ready).
- in_ready SHALL be 0 while flush=1.
REQ-018 Field packing SHALL use the opcodes 0000011, 0010011, 0100011, 1100011 and 0110111.
- I: imm[11:0],rs1,funct3,rd,opc.
- S: imm[11:5],rs2,rs1,funct3,imm[4:0],opc.
- B: imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opc.
- LUI: imm[19:0],rd,opc.
REQ-019 Range rules:
- I/S: in_imm[31:11] all equal.
- B: in_imm[31:12] all equal and in_imm[0]=0.
- LUI: in_imm[31:20]=0.
- Unknown fmt: always an error.
REQ-020 On error, out_inst SHALL be 32'h00000013 (NOP) and out_err SHALL be 1; otherwise out_err=0.
REQ-021 Round-trip: for every non-error result, the immediate generator applied to out_inst SHALL return in_imm.
REQ-022 out_addr SHALL start at 0, increment by 4 after each output transfer (error results included), and wrap at 2^32.
REQ-023 ok_cnt / err_cnt SHALL increment on output transfer per out_err and hold at all-ones.
REQ-024 out_inst, out_err and out_addr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 On flush, both stage valids SHALL clear next cycle.
- A simultaneous input is not accepted.
- An output transfer in the same cycle still counts and still advances out_addr.
- Counters are otherwise kept.

Reset
REQ-026 On reset, all stage valids, out_inst, out_err, out_addr, ok_cnt and err_cnt SHALL be 0 next cycle.
- in_ready reads 0 during reset and 1 the cycle after.
REQ-027 Reset during operation SHALL discard in-flight entries with no output transfer; reset overrides flush.

Structure
REQ-028 Package riscv_enc_pkg SHALL hold:
- the fmt enum;
- opcode constants;
- the NOP constant;
- the stage struct (valid, inst, err).
REQ-029 Combinational packing and range checking SHALL live in sub-module inst_enc_pack; inst_encoder holds the pipeline registers and counters.

Verification
REQ-030 LUI rd=5 imm=0x12345 -> out_inst=0x123452B7, err=0, out_addr=0.
REQ-031 I_ALU rd=1 rs1=0 f3=0 imm=0xFFFFFFFF -> 0xFFF00093.
- Next: S f3=2 rs1=3 rs2=2 imm=8 -> 0x0021A423, out_addr=4.
REQ-032 B f3=0 rs1=1 rs2=2 imm=0xFFFFFFFC -> 0xFE208EE3.
- Then imm=3 -> 0x00000013, err=1, err_cnt=1.
REQ-033 I_ALU imm=2048 -> NOP, err=1; imm=-2048 -> 0x80000013 with rd=0, rs1=0, no error.
REQ-034 Backpressure: out_ready=0 for 6 cycles while 3 requests are offered.
- Exactly 2 requests are accepted and in_ready drops.
- After release, results arrive in order at out_addr 0, 4, 8 with no loss.
REQ-035 Flush with both stages full, and separately reset mid-stream:
- No further out_valid from the dropped entries.
- After flush, out_addr continues from its prior value.
- After reset, out_addr and both counters are 0.

Source files
------------

// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg: shared formats, opcodes and pipeline stage type for the instruction encoder
package riscv_enc_pkg;
   typedef enum logic [2:0] {
      I_LOAD = 3'd0,
      I_ALU  = 3'd1,
      S      = 3'd2,
      B      = 3'd3,
      U_LUI  = 3'd4
   } fmt_e;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_ALU    = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [31:0] NOP = 32'h00000013;
   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic        err;
   } stage_t;
endpackage

// File: rtl/inst_enc_pack.sv
// inst_enc_pack: packs instruction fields and range-checks the immediate, substituting NOP on error
module inst_enc_pack import riscv_enc_pkg::*; (
   input  logic [2:0]  fmt,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        err
);
   logic [31:0] raw;
   logic        ok;
   logic        i_ok;
   logic        b_ok;
   logic        u_ok;
   assign i_ok = &imm[31:11] | ~|imm[31:11];
   assign b_ok = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
   assign u_ok = ~|imm[31:20];
   // select the field layout and range rule for the requested format
   always_comb begin
      raw = NOP;
      ok  = 1'b0;
      case (fmt)
         I_LOAD: begin raw = {imm[11:0], rs1, funct3, rd, OPC_LOAD}; ok = i_ok; end
         I_ALU:  begin raw = {imm[11:0], rs1, funct3, rd, OPC_ALU}; ok = i_ok; end
         S:      begin raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE}; ok = i_ok; end
         B:      begin raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH}; ok = b_ok; end
         U_LUI:  begin raw = {imm[19:0], rd, OPC_LUI}; ok = u_ok; end
         default: ;
      endcase
      err  = !ok;
      inst = ok ? raw : NOP;
   end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: elastic two-stage instruction encoder with output address and result counters
module inst_encoder import riscv_enc_pkg::*; (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_err,
   output logic [31:0] out_addr,
   output logic [15:0] ok_cnt,
   output logic [7:0]  err_cnt
);
   stage_t      s1_q, s1_d, s2_q, s2_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] ok_q, ok_d;
   logic [7:0]  err_q, err_d;
   logic [31:0] pack_inst;
   logic        pack_err;
   logic        s1_moves;
   logic        in_fire;
   logic        out_fire;
   logic        unused_funct7;
   inst_enc_pack u_pack (
      .fmt    (in_fmt),
      .funct3 (in_funct3),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .imm    (in_imm),
      .inst   (pack_inst),
      .err    (pack_err)
   );
   assign unused_funct7 = ^in_funct7;
   assign s1_moves = s1_q.valid & (!s2_q.valid | out_ready);
   assign in_ready = !reset & !flush & (!s1_q.valid | s1_moves);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = s2_q.valid & out_ready;
   assign out_valid = s2_q.valid;
   assign out_inst  = s2_q.inst;
   assign out_err   = s2_q.err;
   assign out_addr  = addr_q;
   assign ok_cnt    = ok_q;
   assign err_cnt   = err_q;
   // stage advance, flush drop, address step and saturating counters
   always_comb begin
      s1_d = s1_q;
      s2_d = s2_q;
      if (in_fire) s1_d = {1'b1, pack_inst, pack_err};
      else if (s1_moves) s1_d.valid = 1'b0;
      if (s1_moves) s2_d = s1_q;
      else if (out_fire) s2_d.valid = 1'b0;
      if (flush) begin
         s1_d.valid = 1'b0;
         s2_d.valid = 1'b0;
      end
      addr_d = out_fire ? addr_q + 32'd4 : addr_q;
      ok_d   = (out_fire & !s2_q.err & ~&ok_q) ? ok_q + 16'd1 : ok_q;
      err_d  = (out_fire & s2_q.err & ~&err_q) ? err_q + 8'd1 : err_q;
   end
   // pipeline and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         addr_q <= '0;
         ok_q   <= '0;
         err_q  <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         addr_q <= addr_d;
         ok_q   <= ok_d;
         err_q  <= err_d;
      end
   end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomized checks of inst_encoder against a queue-based reference model
module tb_inst_encoder;
   localparam logic [2:0] F_LOAD = 3'd0, F_ALU = 3'd1, F_S = 3'd2, F_B = 3'd3, F_LUI = 3'd4, F_BAD = 3'd7;
   typedef struct {
      logic [31:0] inst;
      logic        err;
      logic [31:0] imm;
      logic [2:0]  fmt;
   } exp_t;
   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [2:0]  in_fmt, in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm, out_inst, out_addr;
   logic [15:0] ok_cnt;
   logic [7:0]  err_cnt;
   exp_t        q[$];
   exp_t        drv_exp;
   int          checks = 0;
   int          passes = 0;
   logic [31:0] m_addr = 0;
   int          m_ok = 0;
   int          m_err = 0;
   bit          fired = 0;
   bit          stall_prev = 0;
   logic [31:0] prev_inst, prev_addr;
   logic        prev_err;
   logic [31:0] edges [12] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4095,
                               32'd4096, 32'hFFFFF000, 32'hFFFFEFFE, 32'h000FFFFF, 32'h00100000, 32'd0};
   always #5 clk = ~clk;
   inst_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_err   (out_err),
      .out_addr  (out_addr),
      .ok_cnt    (ok_cnt),
      .err_cnt   (err_cnt)
   );
   function automatic exp_t model(input logic [2:0] f, input logic [2:0] f3, input logic [4:0] d,
                                  input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm);
      exp_t   e;
      longint v;
      bit     ok;
      v = longint'($signed(imm));
      ok = 0;
      e.inst = 32'h13;
      if (f == F_LOAD || f == F_ALU) begin
         ok = v >= -2048 && v <= 2047;
         e.inst = {imm[11:0], s1, f3, d, (f == F_LOAD) ? 7'b0000011 : 7'b0010011};
      end else if (f == F_S) begin
         ok = v >= -2048 && v <= 2047;
         e.inst = {imm[11:5], s2, s1, f3, imm[4:0], 7'b0100011};
      end else if (f == F_B) begin
         ok = v >= -4096 && v <= 4095 && imm[0] == 1'b0;
         e.inst = {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'b1100011};
      end else if (f == F_LUI) begin
         ok = imm < 32'h00100000;
         e.inst = {imm[19:0], d, 7'b0110111};
      end
      if (!ok) e.inst = 32'h13;
      e.err = !ok;
      e.imm = imm;
      e.fmt = f;
      return e;
   endfunction
   function automatic logic [31:0] imm_gen(input logic [2:0] f, input logic [31:0] w);
      if (f == F_S) return {{20{w[31]}}, w[31:25], w[11:7]};
      if (f == F_B) return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      if (f == F_LUI) return {12'd0, w[31:12]};
      return {{20{w[31]}}, w[31:20]};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask
   task automatic set_in(input logic [2:0] f, input logic [2:0] f3, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm);
      in_fmt = f;
      in_funct3 = f3;
      in_funct7 = 7'($urandom);
      in_rd = d;
      in_rs1 = s1;
      in_rs2 = s2;
      in_imm = imm;
      drv_exp = model(f, f3, d, s1, s2, imm);
   endtask
   task automatic set_lit(input logic [2:0] f, input logic [2:0] f3, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm,
                          input logic [31:0] inst, input logic err);
      set_in(f, f3, d, s1, s2, imm);
      drv_exp.inst = inst;
      drv_exp.err = err;
   endtask
   task automatic tick();
      exp_t e;
      bit   xfer, rst_s, fl_s;
      #2;
      rst_s = reset;
      fl_s = flush;
      fired = in_valid && in_ready;
      xfer = out_valid && out_ready && !reset;
      if (stall_prev) begin
         chk("stable_inst", out_inst, prev_inst);
         chk("stable_err", 32'(out_err), 32'(prev_err));
         chk("stable_addr", out_addr, prev_addr);
      end
      chk("in_ready", 32'(in_ready), 32'(!reset && !flush && (q.size() < 2 || out_ready)));
      if (!reset && q.size() == 0) chk("idle_out_valid", 32'(out_valid), 32'd0);
      if (xfer && q.size() > 0) begin
         e = q.pop_front();
         chk("out_inst", out_inst, e.inst);
         chk("out_err", 32'(out_err), 32'(e.err));
         chk("out_addr", out_addr, m_addr);
         if (!e.err) chk("roundtrip", imm_gen(e.fmt, out_inst), e.imm);
         m_addr += 32'd4;
         if (e.err) m_err = (m_err < 255) ? m_err + 1 : m_err;
         else m_ok = (m_ok < 65535) ? m_ok + 1 : m_ok;
      end
      stall_prev = out_valid && !out_ready && !reset && !flush;
      prev_inst = out_inst;
      prev_err = out_err;
      prev_addr = out_addr;
      if (fired) q.push_back(drv_exp);
      @(posedge clk);
      #1;
      if (rst_s) begin
         q.delete();
         m_addr = 0;
         m_ok = 0;
         m_err = 0;
      end else if (fl_s) q.delete();
      if (xfer || rst_s) begin
         chk("ok_cnt", 32'(ok_cnt), 32'(m_ok));
         chk("err_cnt", 32'(err_cnt), 32'(m_err));
      end
   endtask
   task automatic send();
      int n;
      n = 0;
      in_valid = 1'b1;
      do begin
         tick();
         n++;
      end while (!fired && n < 20);
      if (!fired) chk("accept_timeout", 32'(fired), 32'd1);
      in_valid = 1'b0;
   endtask
   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         tick();
         n++;
      end
      if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask
   task automatic one(input logic [2:0] f, input logic [2:0] f3, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm,
                      input logic [31:0] inst, input logic err);
      set_lit(f, f3, d, s1, s2, imm, inst, err);
      send();
      drain();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passes, checks);
      $fatal(1, "watchdog expired");
   end
   initial begin
      int idx;
      int n;
      reset = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      set_in(F_ALU, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_out_addr", out_addr, 32'd0);
      chk("rst_ok_cnt", 32'(ok_cnt), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      // backpressure: three offered, two taken while the output is stalled
      out_ready = 1'b0;
      idx = 0;
      set_in(F_LUI, 0, 5'(idx + 1), 0, 0, 32'(idx + 1));
      in_valid = 1'b1;
      repeat (6) begin
         tick();
         if (fired) begin
            idx++;
            if (idx < 3) set_in(F_LUI, 0, 5'(idx + 1), 0, 0, 32'(idx + 1));
         end
      end
      chk("bp_accepted", 32'(idx), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      n = 0;
      while (idx < 3 && n < 20) begin
         tick();
         if (fired) idx++;
         n++;
      end
      chk("bp_third_accepted", 32'(idx), 32'd3);
      in_valid = 1'b0;
      drain();
      chk("bp_addr_after", out_addr, 32'd12);
      // directed encodings, with a latency probe on the first
      set_lit(F_LUI, 0, 5, 0, 0, 32'h12345, 32'h123452B7, 1'b0);
      send();
      chk("latency_c1", 32'(out_valid), 32'd0);
      tick();
      chk("latency_c2", 32'(out_valid), 32'd1);
      drain();
      one(F_ALU, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
      one(F_S, 2, 0, 3, 2, 32'd8, 32'h0021A423, 1'b0);
      one(F_B, 0, 0, 1, 2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
      one(F_B, 0, 0, 1, 2, 32'd3, 32'h00000013, 1'b1);
      one(F_ALU, 0, 0, 0, 0, 32'd2048, 32'h00000013, 1'b1);
      one(F_ALU, 0, 0, 0, 0, 32'hFFFFF800, 32'h80000013, 1'b0);
      one(F_LOAD, 3, 7, 9, 0, 32'd2047, 32'h7FF4B383, 1'b0);
      one(F_BAD, 0, 1, 1, 1, 32'd0, 32'h00000013, 1'b1);
      chk("dir_err_cnt", 32'(err_cnt), 32'd3);
      // randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         int k;
         logic [31:0] imm;
         k = $urandom_range(0, 3);
         imm = (k == 0) ? $urandom : (k == 1) ? $urandom_range(0, 8191) - 32'd4096 :
               (k == 2) ? $urandom_range(0, 32'h1FFFFF) : edges[$urandom_range(0, 11)];
         set_in(3'($urandom_range(0, 7)), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      // flush with both stages full and a simultaneous output transfer
      out_ready = 1'b0;
      set_in(F_ALU, 1, 2, 3, 4, 32'd100);
      in_valid = 1'b1;
      tick();
      tick();
      chk("flush_fill", 32'(q.size()), 32'd2);
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("flush_no_accept", 32'(fired), 32'd0);
      flush = 1'b0;
      in_valid = 1'b0;
      repeat (3) tick();
      chk("flush_dropped", 32'(out_valid), 32'd0);
      chk("flush_addr_kept", out_addr, m_addr);
      set_in(F_S, 0, 0, 1, 2, 32'hFFFFFFF0);
      send();
      drain();
      // saturate the error counter
      set_in(F_BAD, 0, 0, 0, 0, 32'd0);
      in_valid = 1'b1;
      repeat (270) tick();
      in_valid = 1'b0;
      drain();
      chk("err_cnt_sat", 32'(err_cnt), 32'd255);
      // reset mid-stream discards in-flight entries without a transfer
      out_ready = 1'b0;
      set_in(F_LUI, 0, 3, 0, 0, 32'h00ABC);
      in_valid = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      out_ready = 1'b1;
      tick();
      reset = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_addr", out_addr, 32'd0);
      chk("mid_rst_ok", 32'(ok_cnt), 32'd0);
      chk("mid_rst_err", 32'(err_cnt), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (3) tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
